// File: rtl/song_sequencer.sv
// Song sequencer: walks {song, idx} through a song ROM and hands note/duration pairs to a note player.
// All outputs registered; load_new_note and song_done pulse in the cycle after the LOAD/END state.
module song_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                   rom_data,
  output logic                          load_new_note,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration_to_load,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_END
  } state_t;

  state_t                        r_state;
  logic [SONG_BITS-1:0]          r_song_q;
  logic [IDX_BITS-1:0]           r_idx;
  logic [SONG_BITS+IDX_BITS-1:0] r_rom_addr;
  logic [5:0]                    r_note;
  logic [5:0]                    r_dur;
  logic                          r_load_new_note;
  logic                          r_song_done;

  logic                          w_song_chg;
  logic                          w_last_idx;
  logic                          w_end_marker;
  logic [IDX_BITS-1:0]           w_idx_inc;

  assign w_song_chg   = (song != r_song_q);
  assign w_last_idx   = &r_idx;
  assign w_end_marker = (rom_data[5:0] == 6'd0);
  assign w_idx_inc    = r_idx + 1'b1;

  // rom_addr is rewritten whenever song_q or idx change, so it always equals {song_q, idx}
  // and the synchronous ROM has a full cycle to respond before WAIT_ROM samples it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_song_q        <= '0;
      r_idx           <= '0;
      r_rom_addr      <= '0;
      r_note          <= '0;
      r_dur           <= '0;
      r_load_new_note <= 1'b0;
      r_song_done     <= 1'b0;
    end else if (w_song_chg) begin
      r_song_q        <= song;
      r_idx           <= '0;
      r_rom_addr      <= {song, {IDX_BITS{1'b0}}};
      r_state         <= ST_IDLE;
      r_load_new_note <= 1'b0;
      r_song_done     <= 1'b0;
    end else begin
      r_load_new_note <= (r_state == ST_LOAD);
      r_song_done     <= (r_state == ST_END);
      case (r_state)
        ST_IDLE: begin
          if (play) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (play) r_state <= ST_WAIT_ROM;
        end
        ST_WAIT_ROM: begin
          if (play) begin
            if (w_end_marker) begin
              r_state <= ST_END;
            end else begin
              r_note  <= rom_data[11:6];
              r_dur   <= rom_data[5:0];
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Last slot ends the song rather than wrapping the index.
          if (note_done) begin
            if (w_last_idx) begin
              r_state <= ST_END;
            end else begin
              r_idx      <= w_idx_inc;
              r_rom_addr <= {r_song_q, w_idx_inc};
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_END: begin
          r_idx      <= '0;
          r_rom_addr <= {r_song_q, {IDX_BITS{1'b0}}};
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr         = r_rom_addr;
  assign note_to_load     = r_note;
  assign duration_to_load = r_dur;
  assign load_new_note    = r_load_new_note;
  assign song_done        = r_song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: synchronous ROM model plus a song-level reference (note lists per song).
module tb_song_sequencer;
  localparam int SB = 2;
  localparam int IB = 5;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b1;
  logic              play      = 1'b0;
  logic              note_done = 1'b0;
  logic [SB-1:0]     song      = '0;
  logic [11:0]       rom_data;
  logic [SB+IB-1:0]  rom_addr;
  logic              load_new_note;
  logic              song_done;
  logic [5:0]        note_to_load;
  logic [5:0]        duration_to_load;

  logic [11:0]       mem [0:127];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  song_sequencer #(.SONG_BITS(SB), .IDX_BITS(IB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .song_done        (song_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a song is its ROM words up to (not including) the first zero duration, max 32.
  function automatic int song_len(input int s);
    for (int i = 0; i < 32; i++)
      if (mem[s*32 + i][5:0] == 6'd0) return i;
    return 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (load_new_note === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_load(input int s, input int i);
    logic [11:0] w;
    w = mem[s*32 + i];
    chk("note_to_load", note_to_load, w[11:6]);
    chk("duration_to_load", duration_to_load, w[5:0]);
  endtask

  task automatic pulse_done();
    repeat ($urandom_range(0, 3)) tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  task automatic play_song(input int s, input int i0);
    bit seen;
    bit saw_done;
    bit saw_load;
    int len;
    len = song_len(s);
    for (int i = i0; i < len; i++) begin
      wait_load(seen);
      chk("load_seen", seen, 1);
      check_load(s, i);
      pulse_done();
    end
    saw_done = 1'b0;
    saw_load = 1'b0;
    for (int n = 0; n < 40 && !saw_done; n++) begin
      tick();
      if (load_new_note === 1'b1) saw_load = 1'b1;
      if (song_done === 1'b1) saw_done = 1'b1;
    end
    chk("song_done_seen", saw_done, 1);
    chk("no_load_after_last", saw_load, 0);
    chk("rom_addr_after_end", rom_addr, s*32);
    tick();
    chk("song_done_one_cycle", song_done, 0);
  endtask

  initial begin
    bit   seen;
    int   e2;
    logic [5:0] n6;
    logic [5:0] d6;

    for (int a = 0; a < 128; a++) begin
      n6 = 6'($urandom_range(0, 63));
      d6 = 6'($urandom_range(1, 63));
      mem[a] = {n6, d6};
    end
    mem[0]  = 12'h041;
    mem[1]  = 12'h083;
    mem[2]  = 12'h000;
    mem[34] = 12'h000;
    e2 = $urandom_range(2, 8);
    mem[64 + e2] = 12'h000;

    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_load", load_new_note, 0);
    chk("rst_note", note_to_load, 0);
    chk("rst_dur", duration_to_load, 0);
    chk("rst_song_done", song_done, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Play latency from IDLE and the two-word song 0.
    play = 1'b1;
    tick(); chk("lat_idle_1", load_new_note, 0);
    tick(); chk("lat_idle_2", load_new_note, 0);
    tick(); chk("lat_idle_3", load_new_note, 0);
    tick(); chk("lat_idle_4", load_new_note, 1);
    check_load(0, 0);
    tick(); chk("load_one_cycle", load_new_note, 0);
    pulse_done();
    play_song(0, 1);

    // Song 1 ends on the zero-duration word at 0x22.
    play = 1'b0;
    song = 2'd1;
    play = 1'b1;
    play_song(1, 0);

    // Song change 0->2 in WAIT_DONE together with note_done.
    play = 1'b0;
    song = 2'd0;
    play = 1'b1;
    wait_load(seen);
    chk("load_seen_s0", seen, 1);
    check_load(0, 0);
    song = 2'd2;
    note_done = 1'b1;
    tick();
    chk("chg_rom_addr", rom_addr, 7'h40);
    chk("chg_load", load_new_note, 0);
    chk("chg_song_done", song_done, 0);
    note_done = 1'b0;
    play = 1'b0;
    tick();
    chk("chg_song_done_2", song_done, 0);

    // Pause in FETCH holds the address and suppresses loads.
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("pause_rom_addr", rom_addr, 7'h40);
      chk("pause_load", load_new_note, 0);
    end
    play = 1'b1;
    tick(); chk("lat_fetch_1", load_new_note, 0);
    tick(); chk("lat_fetch_2", load_new_note, 0);
    tick(); chk("lat_fetch_3", load_new_note, 1);
    check_load(2, 0);
    pulse_done();
    play_song(2, 1);

    // Full 32-note song 3, then continuous play loops back to idx 0.
    play = 1'b0;
    song = 2'd3;
    play = 1'b1;
    play_song(3, 0);
    wait_load(seen);
    chk("loop_load_seen", seen, 1);
    check_load(3, 0);

    // Reset pulse mid-WAIT_DONE without a clock edge.
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_load", load_new_note, 0);
    chk("mid_rst_note", note_to_load, 0);
    chk("mid_rst_dur", duration_to_load, 0);
    chk("mid_rst_song_done", song_done, 0);
    #1 reset_n = 1'b1;
    play = 1'b0;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("post_rst_rom_addr", rom_addr, 7'h60);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_load", load_new_note, 0);
      chk("post_rst_song_done", song_done, 0);
    end
    play = 1'b1;
    wait_load(seen);
    chk("post_rst_load_seen", seen, 1);
    check_load(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
